// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the MEM-stage access unit and the SRAM-like port.
// master = access unit, slave = memory side.
interface mem_access_unit_if;
  logic        data_req;
  logic        data_wr;
  logic [31:0] data_addr;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_addr,
    output data_be, data_wdata,
    input  data_addr_ok, data_data_ok,
    input  data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_addr,
    input  data_be, data_wdata,
    output data_addr_ok, data_data_ok,
    output data_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data access unit: bus request FSM, store encode, load align.
// Optional MEM_ALIGN_CHECK_EN raises mem_adel/mem_ades on misaligned access.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [2:0]  mem_load_type,
  input  logic [1:0]  mem_store_type,
  input  logic        mem_flush,
  input  logic        mem_advance,
  mem_access_unit_if.master bus,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        mem_adel,
  output logic        mem_ades
);
  localparam logic [2:0] LB  = 3'd1;
  localparam logic [2:0] LBU = 3'd2;
  localparam logic [2:0] LH  = 3'd3;
  localparam logic [2:0] LHU = 3'd4;
  localparam logic [2:0] LW  = 3'd5;
  localparam logic [1:0] SB  = 2'd1;
  localparam logic [1:0] SH  = 2'd2;
  localparam logic [1:0] SW  = 2'd3;

  typedef enum logic [2:0] {
    IDLE, ADDR, DATA, HOLD, DRAIN
  } state_t;

  state_t state, state_n;

  logic        is_st, is_ld, access;
  logic        cancel;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        r_wr;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [2:0]  r_ltype;
  logic [1:0]  r_off;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_res;

  assign is_st = mem_store_type != 2'd0;
  assign is_ld = !is_st && mem_load_type >= LB
              && mem_load_type <= LW;

`ifdef MEM_ALIGN_CHECK_EN
  logic ld_mis, st_mis;
  assign ld_mis =
    ((mem_load_type == LH || mem_load_type == LHU)
      && mem_addr[0])
    || (mem_load_type == LW && mem_addr[1:0] != 2'd0);
  assign st_mis =
    (mem_store_type == SH && mem_addr[0])
    || (mem_store_type == SW && mem_addr[1:0] != 2'd0);
  assign mem_adel = rst && mem_valid && is_ld && ld_mis;
  assign mem_ades = rst && mem_valid && is_st && st_mis;
`else
  assign mem_adel = 1'b0;
  assign mem_ades = 1'b0;
`endif

  assign access = rst && mem_valid && (is_ld || is_st)
               && !mem_adel && !mem_ades && !mem_flush;

  always_comb begin
    req_be    = 4'b0000;
    req_wdata = mem_wdata;
    unique case (1'b1)
      mem_store_type == SB: begin
        req_be    = 4'b0001 << mem_addr[1:0];
        req_wdata = {4{mem_wdata[7:0]}};
      end
      mem_store_type == SH: begin
        req_be    = mem_addr[1] ? 4'b1100 : 4'b0011;
        req_wdata = {2{mem_wdata[15:0]}};
      end
      mem_store_type == SW: req_be = 4'b1111;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:
        if (access)
          state_n = bus.data_addr_ok ? DATA : ADDR;
      ADDR:
        if (bus.data_addr_ok)
          state_n = (cancel || mem_flush) ? DRAIN : DATA;
      // a response landing with the flush is already consumed
      DATA:
        if (bus.data_data_ok)
          state_n = mem_flush ? IDLE : HOLD;
        else if (mem_flush)
          state_n = DRAIN;
      HOLD:
        if (mem_advance || mem_flush) state_n = IDLE;
      DRAIN:
        if (bus.data_data_ok) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.data_req   = 1'b0;
    bus.data_wr    = is_st;
    bus.data_addr  = {mem_addr[31:2], 2'b00};
    bus.data_be    = req_be;
    bus.data_wdata = req_wdata;
    mem_stall      = 1'b0;
    if (state != IDLE) begin
      bus.data_wr    = r_wr;
      bus.data_addr  = r_addr;
      bus.data_be    = r_be;
      bus.data_wdata = r_wdata;
    end
    case (state)
      IDLE: begin
        bus.data_req = access;
        mem_stall    = access;
      end
      ADDR: begin
        bus.data_req = 1'b1;
        mem_stall    = 1'b1;
      end
      DATA, DRAIN: mem_stall = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    ld_b = bus.data_rdata[{r_off, 3'b000} +: 8];
    ld_h = r_off[1] ? bus.data_rdata[31:16]
                    : bus.data_rdata[15:0];
    case (r_ltype)
      LB:      ld_res = {{24{ld_b[7]}}, ld_b};
      LBU:     ld_res = {24'd0, ld_b};
      LH:      ld_res = {{16{ld_h[15]}}, ld_h};
      LHU:     ld_res = {16'd0, ld_h};
      default: ld_res = bus.data_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cancel    <= 1'b0;
      r_wr      <= 1'b0;
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_ltype   <= '0;
      r_off     <= '0;
      mem_rdata <= '0;
    end else begin
      if (state == IDLE && access) begin
        r_wr    <= is_st;
        r_addr  <= {mem_addr[31:2], 2'b00};
        r_be    <= req_be;
        r_wdata <= req_wdata;
        r_ltype <= mem_load_type;
        r_off   <= mem_addr[1:0];
      end
      if (state == ADDR)
        cancel <= (cancel | mem_flush) & ~bus.data_addr_ok;
      else
        cancel <= 1'b0;
      if (state == DATA && bus.data_data_ok
          && !mem_flush && !r_wr)
        mem_rdata <= ld_res;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit.
// Build with or without MEM_ALIGN_CHECK_EN.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_load_type;
  logic [1:0]  mem_store_type;
  logic        mem_flush;
  logic        mem_advance;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic        mem_adel;
  logic        mem_ades;

  int total = 0;
  int bad   = 0;

  // results of the last run_access
  int          stalls, req_cyc;
  logic        stable, hold_stall;
  logic        a_wr;
  logic [31:0] a_addr, a_wdata;
  logic [3:0]  a_be;

  mem_access_unit_if bus();

  mem_access_unit dut (
    .clk(clk),
    .rst(rst),
    .mem_valid(mem_valid),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_load_type(mem_load_type),
    .mem_store_type(mem_store_type),
    .mem_flush(mem_flush),
    .mem_advance(mem_advance),
    .bus(bus),
    .mem_rdata(mem_rdata),
    .mem_stall(mem_stall),
    .mem_adel(mem_adel),
    .mem_ades(mem_ades)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid          = 1'b0;
    mem_addr           = '0;
    mem_wdata          = '0;
    mem_load_type      = '0;
    mem_store_type     = '0;
    mem_flush          = 1'b0;
    mem_advance        = 1'b0;
    bus.data_addr_ok   = 1'b0;
    bus.data_data_ok   = 1'b0;
    bus.data_rdata     = '0;
  endtask

  // drives one complete access; addr_ok after adly wait cycles,
  // data_ok the cycle after, then advances out of HOLD
  task automatic run_access(
    input logic [31:0] addr, input logic [31:0] wdata,
    input logic [31:0] rdata, input logic [2:0] lt,
    input logic [1:0] st, input int adly);
    mem_valid      = 1'b1;
    mem_addr       = addr;
    mem_wdata      = wdata;
    mem_load_type  = lt;
    mem_store_type = st;
    stalls  = 0;
    req_cyc = 0;
    stable  = 1'b1;
    for (int k = 0; k <= adly; k++) begin
      bus.data_addr_ok = (k == adly);
      bus.data_data_ok = 1'b0;
      @(negedge clk);
      if (mem_stall) stalls++;
      if (bus.data_req) begin
        req_cyc++;
        if (k == 0) begin
          a_wr    = bus.data_wr;
          a_addr  = bus.data_addr;
          a_be    = bus.data_be;
          a_wdata = bus.data_wdata;
        end else if (bus.data_wr !== a_wr
                     || bus.data_addr !== a_addr
                     || bus.data_be !== a_be
                     || bus.data_wdata !== a_wdata) begin
          stable = 1'b0;
        end
      end
      step();
    end
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b1;
    bus.data_rdata   = rdata;
    @(negedge clk);
    if (mem_stall) stalls++;
    step();
    bus.data_data_ok = 1'b0;
    @(negedge clk);
    hold_stall  = mem_stall;
    mem_advance = 1'b1;
    step();
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    mem_valid     = 1'b1;
    mem_load_type = 3'd5;
    mem_addr      = 32'h0000_0100;
    bus.data_addr_ok = 1'b1;
    step();
    @(negedge clk);
    total++;
    if (bus.data_req !== 1'b0) begin
      bad++;
      $display("FAIL reset_req got=%b exp=0", bus.data_req);
    end
    total++;
    if (mem_stall !== 1'b0) begin
      bad++;
      $display("FAIL reset_stall got=%b exp=0", mem_stall);
    end
    total++;
    if (mem_rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_rdata got=%h exp=0", mem_rdata);
    end
    idle_inputs();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_lb();
    run_access(32'h0000_1003, 32'h0, 32'h80AA_BBCC,
               3'd1, 2'd0, 0);
    total++;
    if (mem_rdata !== 32'hFFFF_FF80) begin
      bad++;
      $display("FAIL lb_data got=%h exp=ffffff80", mem_rdata);
    end
    total++;
    if (stalls != 2) begin
      bad++;
      $display("FAIL lb_stall_cycles got=%0d exp=2", stalls);
    end
    total++;
    if (hold_stall !== 1'b0) begin
      bad++;
      $display("FAIL lb_hold_stall got=%b exp=0", hold_stall);
    end
    total++;
    if (a_addr !== 32'h0000_1000 || a_be !== 4'b0000
        || a_wr !== 1'b0) begin
      bad++;
      $display("FAIL lb_req got=%h/%b/%b exp=00001000/0000/0",
               a_addr, a_be, a_wr);
    end
    run_access(32'h0000_1003, 32'h0, 32'h80AA_BBCC,
               3'd2, 2'd0, 0);
    total++;
    if (mem_rdata !== 32'h0000_0080) begin
      bad++;
      $display("FAIL lbu_data got=%h exp=00000080", mem_rdata);
    end
  endtask

  task automatic test_sb();
    run_access(32'h0000_1001, 32'h0000_00AB, 32'h5555_5555,
               3'd0, 2'd1, 0);
    total++;
    if (a_be !== 4'b0010) begin
      bad++;
      $display("FAIL sb_be got=%b exp=0010", a_be);
    end
    total++;
    if (a_wdata !== 32'hABAB_ABAB) begin
      bad++;
      $display("FAIL sb_wdata got=%h exp=abababab", a_wdata);
    end
    total++;
    if (a_addr !== 32'h0000_1000 || a_wr !== 1'b1) begin
      bad++;
      $display("FAIL sb_addr got=%h/%b exp=00001000/1",
               a_addr, a_wr);
    end
    total++;
    if (mem_rdata !== 32'h0000_0080) begin
      bad++;
      $display("FAIL sb_rdata_kept got=%h exp=00000080",
               mem_rdata);
    end
  endtask

  task automatic test_lh_delay();
    run_access(32'h0000_2002, 32'h0, 32'h8001_1234,
               3'd3, 2'd0, 3);
    total++;
    if (req_cyc != 4 || stable !== 1'b1) begin
      bad++;
      $display("FAIL lh_req_hold got=%0d/%b exp=4/1",
               req_cyc, stable);
    end
    total++;
    if (stalls != 5) begin
      bad++;
      $display("FAIL lh_stall_cycles got=%0d exp=5", stalls);
    end
    total++;
    if (mem_rdata !== 32'hFFFF_8001) begin
      bad++;
      $display("FAIL lh_data got=%h exp=ffff8001", mem_rdata);
    end
    run_access(32'h0000_2002, 32'h0, 32'h8001_1234,
               3'd4, 2'd0, 1);
    total++;
    if (mem_rdata !== 32'h0000_8001) begin
      bad++;
      $display("FAIL lhu_data got=%h exp=00008001", mem_rdata);
    end
  endtask

  task automatic test_flush();
    run_access(32'h0000_4000, 32'h0, 32'h1234_5678,
               3'd5, 2'd0, 0);
    total++;
    if (mem_rdata !== 32'h1234_5678) begin
      bad++;
      $display("FAIL lw_data got=%h exp=12345678", mem_rdata);
    end
    mem_valid        = 1'b1;
    mem_load_type    = 3'd5;
    mem_addr         = 32'h0000_4004;
    bus.data_addr_ok = 1'b1;
    step();
    bus.data_addr_ok = 1'b0;
    mem_flush        = 1'b1;
    @(negedge clk);
    total++;
    if (mem_stall !== 1'b1) begin
      bad++;
      $display("FAIL flush_data_stall got=%b exp=1", mem_stall);
    end
    step();
    idle_inputs();
    @(negedge clk);
    total++;
    if (mem_stall !== 1'b1) begin
      bad++;
      $display("FAIL drain_stall got=%b exp=1", mem_stall);
    end
    step();
    bus.data_data_ok = 1'b1;
    bus.data_rdata   = 32'hDEAD_BEEF;
    @(negedge clk);
    total++;
    if (mem_stall !== 1'b1) begin
      bad++;
      $display("FAIL drain_ok_stall got=%b exp=1", mem_stall);
    end
    step();
    bus.data_data_ok = 1'b0;
    @(negedge clk);
    total++;
    if (mem_stall !== 1'b0 || bus.data_req !== 1'b0) begin
      bad++;
      $display("FAIL drain_exit got=%b/%b exp=0/0",
               mem_stall, bus.data_req);
    end
    total++;
    if (mem_rdata !== 32'h1234_5678) begin
      bad++;
      $display("FAIL drain_rdata got=%h exp=12345678", mem_rdata);
    end
    // back in IDLE: a fresh access must request at once
    mem_valid     = 1'b1;
    mem_load_type = 3'd5;
    mem_addr      = 32'h0000_4008;
    #1;
    total++;
    if (bus.data_req !== 1'b1) begin
      bad++;
      $display("FAIL post_drain_req got=%b exp=1", bus.data_req);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_misalign();
`ifdef MEM_ALIGN_CHECK_EN
    mem_valid     = 1'b1;
    mem_load_type = 3'd5;
    mem_addr      = 32'h0000_3002;
    @(negedge clk);
    total++;
    if (mem_adel !== 1'b1 || bus.data_req !== 1'b0
        || mem_stall !== 1'b0) begin
      bad++;
      $display("FAIL lw_adel got=%b/%b/%b exp=1/0/0",
               mem_adel, bus.data_req, mem_stall);
    end
    mem_load_type  = 3'd0;
    mem_store_type = 2'd2;
    mem_addr       = 32'h0000_3001;
    #1;
    total++;
    if (mem_ades !== 1'b1 || bus.data_req !== 1'b0) begin
      bad++;
      $display("FAIL sh_ades got=%b/%b exp=1/0",
               mem_ades, bus.data_req);
    end
    idle_inputs();
    step();
`else
    mem_valid     = 1'b1;
    mem_load_type = 3'd5;
    mem_addr      = 32'h0000_3002;
    #1;
    total++;
    if (mem_adel !== 1'b0) begin
      bad++;
      $display("FAIL lw_no_adel got=%b exp=0", mem_adel);
    end
    run_access(32'h0000_3002, 32'h0, 32'hCAFE_F00D,
               3'd5, 2'd0, 0);
    total++;
    if (a_addr !== 32'h0000_3000) begin
      bad++;
      $display("FAIL lw_mis_addr got=%h exp=00003000", a_addr);
    end
    total++;
    if (mem_rdata !== 32'hCAFE_F00D) begin
      bad++;
      $display("FAIL lw_mis_data got=%h exp=cafef00d", mem_rdata);
    end
`endif
  endtask

  task automatic test_reset_mid();
    mem_valid     = 1'b1;
    mem_load_type = 3'd5;
    mem_addr      = 32'h0000_5000;
    step();
    @(negedge clk);
    total++;
    if (bus.data_req !== 1'b1 || mem_stall !== 1'b1) begin
      bad++;
      $display("FAIL addr_wait got=%b/%b exp=1/1",
               bus.data_req, mem_stall);
    end
    #1;
    rst = 1'b0;
    #1;
    total++;
    if (bus.data_req !== 1'b0 || mem_stall !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid got=%b/%b exp=0/0",
               bus.data_req, mem_stall);
    end
    total++;
    if (mem_rdata !== 32'h0) begin
      bad++;
      $display("FAIL rst_mid_rdata got=%h exp=0", mem_rdata);
    end
    idle_inputs();
    step();
    rst = 1'b1;
    step();
    run_access(32'h0000_6000, 32'h1122_3344, 32'h0,
               3'd0, 2'd3, 0);
    total++;
    if (a_be !== 4'b1111 || a_wdata !== 32'h1122_3344
        || a_wr !== 1'b1 || a_addr !== 32'h0000_6000) begin
      bad++;
      $display("FAIL sw_req got=%b/%h/%b/%h exp=1111/11223344/1/00006000",
               a_be, a_wdata, a_wr, a_addr);
    end
    total++;
    if (stalls != 2 || mem_rdata !== 32'h0) begin
      bad++;
      $display("FAIL sw_done got=%0d/%h exp=2/0",
               stalls, mem_rdata);
    end
  endtask

  task automatic test_sh_hi();
    run_access(32'h0000_7002, 32'h0000_BEEF, 32'h0,
               3'd4, 2'd2, 0);
    total++;
    if (a_be !== 4'b1100 || a_wdata !== 32'hBEEF_BEEF
        || a_wr !== 1'b1) begin
      bad++;
      $display("FAIL sh_store_wins got=%b/%h/%b exp=1100/beefbeef/1",
               a_be, a_wdata, a_wr);
    end
  endtask

  initial begin
    test_reset();
    test_lb();
    test_sb();
    test_lh_delay();
    test_flush();
    test_misalign();
    test_sh_hi();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1);
  end
endmodule
